// File: rtl/sensor_conditioner.sv
// sensor_conditioner: samples the dial and CdS ADC readings at a fixed rate,
// smooths each with a power-of-two moving average, and derives a
// hysteresis-stabilised 16-step dial level and dark flag.
//
// Output strobes: upd is a one-cycle pulse marking the cycle in which
// dial_filt, cds_filt, avg_valid, dial_level and dark all hold the values
// for the latest sample; level_chg is a one-cycle pulse in that same cycle
// when dial_level took a new value. There is no back-pressure: consumers
// must take the values while upd is high or read the held outputs later.
module sensor_conditioner #(
   parameter int         SAMPLE_DIV = 500000,
   parameter int         AVG_LOG2   = 2,
   parameter int         HYST       = 3,
   parameter logic [7:0] DARK_ON    = 8'd64,
   parameter logic [7:0] DARK_OFF   = 8'd96
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] dial_raw,
   input  logic [7:0] cds_raw,
   output logic [7:0] dial_filt,
   output logic [7:0] cds_filt,
   output logic [3:0] dial_level,
   output logic       dark,
   output logic       level_chg,
   output logic       upd,
   output logic       avg_valid
);

   localparam int                  WIN       = 1 << AVG_LOG2;
   localparam int                  SUM_W     = 8 + AVG_LOG2;
   localparam int                  CNT_W     = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [AVG_LOG2:0]   FILL_FULL = WIN[AVG_LOG2:0];
   localparam logic [8:0]          HYST9     = 9'(HYST);

   // Sample-rate divider
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tick;

   // Averaging windows (shared write pointer)
   logic [7:0]          dial_ring_q [WIN];
   logic [7:0]          cds_ring_q  [WIN];
   logic [AVG_LOG2-1:0] ptr_q;
   logic [AVG_LOG2:0]   fill_q, fill_d;
   logic [SUM_W-1:0]    dial_sum_q, dial_sum_d;
   logic [SUM_W-1:0]    cds_sum_q, cds_sum_d;

   // Pipeline stage valids
   logic                v1_q;
   logic                v2_q;

   // Registered outputs
   logic [7:0]          dial_filt_q;
   logic [7:0]          cds_filt_q;
   logic                avg_valid_q;
   logic [3:0]          level_q, level_d;
   logic                dark_q, dark_d;
   logic                level_chg_d;
   logic                level_chg_q;
   logic                upd_q;

   // Level thresholds, all evaluated as 9-bit unsigned
   logic [8:0]          filt9;
   logic [8:0]          lvl_lo;
   logic [8:0]          up_thr;
   logic                go_up;
   logic                go_dn;

   // Next-state for the divider, fill counter and running sums
   always_comb begin
      tick       = (cnt_q == CNT_MAX);
      cnt_d      = tick ? '0 : cnt_q + 1'b1;
      fill_d     = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      dial_sum_d = dial_sum_q + SUM_W'(dial_raw) - SUM_W'(dial_ring_q[ptr_q]);
      cds_sum_d  = cds_sum_q  + SUM_W'(cds_raw)  - SUM_W'(cds_ring_q[ptr_q]);
   end

   // Hysteresis decisions for dial level and dark flag (used only in stage 3)
   always_comb begin
      filt9       = {1'b0, dial_filt_q};
      lvl_lo      = {1'b0, level_q, 4'b0000};
      up_thr      = lvl_lo + 9'd16 + HYST9;
      go_up       = (level_q != 4'hF) && (filt9 >= up_thr);
      go_dn       = (level_q != 4'h0) && ((filt9 + HYST9) < lvl_lo);
      level_d     = level_q;
      level_chg_d = 1'b0;
      dark_d      = dark_q;
      if (v2_q) begin
         if (go_up || go_dn) begin
            level_d     = dial_filt_q[7:4];
            level_chg_d = 1'b1;
         end
         if (!dark_q && (cds_filt_q < DARK_ON)) begin
            dark_d = 1'b1;
         end else if (dark_q && (cds_filt_q > DARK_OFF)) begin
            dark_d = 1'b0;
         end
      end
   end

   // Stage 1: divider, raw capture into the rings, running sums
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         ptr_q      <= '0;
         fill_q     <= '0;
         dial_sum_q <= '0;
         cds_sum_q  <= '0;
         v1_q       <= 1'b0;
         for (int i = 0; i < WIN; i++) begin
            dial_ring_q[i] <= '0;
            cds_ring_q[i]  <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         v1_q  <= tick;
         if (tick) begin
            dial_ring_q[ptr_q] <= dial_raw;
            cds_ring_q[ptr_q]  <= cds_raw;
            dial_sum_q         <= dial_sum_d;
            cds_sum_q          <= cds_sum_d;
            ptr_q              <= ptr_q + 1'b1;
            fill_q             <= fill_d;
         end
      end
   end

   // Stage 2: register the averaged values and window-full flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dial_filt_q <= '0;
         cds_filt_q  <= '0;
         avg_valid_q <= 1'b0;
         v2_q        <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            dial_filt_q <= dial_sum_q[SUM_W-1:AVG_LOG2];
            cds_filt_q  <= cds_sum_q[SUM_W-1:AVG_LOG2];
            avg_valid_q <= (fill_q == FILL_FULL);
         end
      end
   end

   // Stage 3: stabilised level / dark flag and the update strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level_q     <= '0;
         dark_q      <= 1'b0;
         level_chg_q <= 1'b0;
         upd_q       <= 1'b0;
      end else begin
         level_q     <= level_d;
         dark_q      <= dark_d;
         level_chg_q <= level_chg_d;
         upd_q       <= v2_q;
      end
   end

   assign dial_filt  = dial_filt_q;
   assign cds_filt   = cds_filt_q;
   assign avg_valid  = avg_valid_q;
   assign dial_level = level_q;
   assign dark       = dark_q;
   assign level_chg  = level_chg_q;
   assign upd        = upd_q;

endmodule
